mmio_lite_master: RTL

//  AXI4-Lite master that drives the MMIO register window (CMD/SRC/DEST/LEN at 0x0-0xC, debug at 0x10-0x1C).

---
 rtl/mmio_pkg.sv | 34 +++
 rtl/mmio_timeout_ctr.sv | 29 ++
 rtl/mmio_lite_master.sv | 187 ++++++++++++++++++
 3 files changed

// File: rtl/mmio_pkg.sv
// Shared definitions for the MMIO AXI4-Lite master: response codes, FSM states,
// register window offsets and the saturating stray-beat adder.
package mmio_pkg;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] RESP_DECERR = 2'b11;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_WADDR = 3'd1,
        ST_WRESP = 3'd2,
        ST_RADDR = 3'd3,
        ST_RDATA = 3'd4,
        ST_RSP   = 3'd5
    } state_t;

    localparam logic [7:0] OFF_CMD  = 8'h00;
    localparam logic [7:0] OFF_SRC  = 8'h04;
    localparam logic [7:0] OFF_DEST = 8'h08;
    localparam logic [7:0] OFF_LEN  = 8'h0C;
    localparam logic [7:0] OFF_DBG0 = 8'h10;
    localparam logic [7:0] OFF_DBG1 = 8'h14;
    localparam logic [7:0] OFF_DBG2 = 8'h18;
    localparam logic [7:0] OFF_DBG3 = 8'h1C;

    // Add up to two absorbed beats to the stray counter, clamping at 255.
    function automatic logic [7:0] stray_add(input logic [7:0] cnt, input logic [1:0] inc);
        logic [8:0] sum;
        sum = {1'b0, cnt} + 9'(inc);
        return (sum > 9'd255) ? 8'hFF : sum[7:0];
    endfunction

endpackage

// File: rtl/mmio_timeout_ctr.sv
// Wait-state watchdog: counts cycles while enabled, pulses expire_c on the
// cycle the count reaches TIMEOUT-1. TIMEOUT=0 never expires.
module mmio_timeout_ctr #(
    parameter int unsigned TIMEOUT = 1024
) (
    input  logic ACLK,
    input  logic ARESETN,
    input  logic clear,
    input  logic enable,
    output logic expire_c
);

    localparam int unsigned CNT_W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
    localparam int unsigned LAST  = (TIMEOUT == 0) ? 0 : TIMEOUT - 1;

    logic [CNT_W-1:0] cnt;

    // Holds at LAST so the count never wraps back into range.
    always_ff @(posedge ACLK) begin
        if (!ARESETN || clear) begin
            cnt <= '0;
        end else if (enable && (cnt != CNT_W'(LAST))) begin
            cnt <= cnt + CNT_W'(1);
        end
    end

    assign expire_c = (TIMEOUT != 0) && enable && (cnt == CNT_W'(LAST));

endmodule

// File: rtl/mmio_lite_master.sv
// AXI4-Lite master for the MMIO register window: one request in, one AXI-Lite
// transaction out, one response back (with timeout on the B/R wait).
module mmio_lite_master
    import mmio_pkg::*;
#(
    parameter int unsigned ADDR_W  = 32,
    parameter int unsigned DATA_W  = 32,
    parameter int unsigned TIMEOUT = 1024
) (
    input  logic                  ACLK,
    input  logic                  ARESETN,
    input  logic                  REQ_VALID,
    output logic                  REQ_READY,
    input  logic                  REQ_WRITE,
    input  logic [ADDR_W-1:0]     REQ_ADDR,
    input  logic [DATA_W-1:0]     REQ_WDATA,
    input  logic [DATA_W/8-1:0]   REQ_WSTRB,
    output logic                  RSP_VALID,
    input  logic                  RSP_READY,
    output logic [DATA_W-1:0]     RSP_RDATA,
    output logic [1:0]            RSP_RESP,
    output logic                  RSP_TIMEOUT,
    output logic [7:0]            STRAY_CNT,
    output logic [ADDR_W-1:0]     M_AXI_AWADDR,
    output logic                  M_AXI_AWVALID,
    input  logic                  M_AXI_AWREADY,
    output logic [DATA_W-1:0]     M_AXI_WDATA,
    output logic [DATA_W/8-1:0]   M_AXI_WSTRB,
    output logic                  M_AXI_WVALID,
    input  logic                  M_AXI_WREADY,
    input  logic [1:0]            M_AXI_BRESP,
    input  logic                  M_AXI_BVALID,
    output logic                  M_AXI_BREADY,
    output logic [ADDR_W-1:0]     M_AXI_ARADDR,
    output logic                  M_AXI_ARVALID,
    input  logic                  M_AXI_ARREADY,
    input  logic [DATA_W-1:0]     M_AXI_RDATA,
    input  logic [1:0]            M_AXI_RRESP,
    input  logic                  M_AXI_RVALID,
    output logic                  M_AXI_RREADY
);

    localparam int unsigned STRB_W = DATA_W / 8;

    state_t              state;
    logic                aw_done;
    logic                w_done;
    logic [ADDR_W-1:0]   addr_q;
    logic [DATA_W-1:0]   wdata_q;
    logic [STRB_W-1:0]   wstrb_q;

    logic                aw_hs;
    logic                w_hs;
    logic                ar_hs;
    logic                wait_st;
    logic                idle_or_rsp;
    logic [1:0]          stray_inc;
    logic                expire;

    assign aw_hs       = M_AXI_AWVALID && M_AXI_AWREADY;
    assign w_hs        = M_AXI_WVALID && M_AXI_WREADY;
    assign ar_hs       = M_AXI_ARVALID && M_AXI_ARREADY;
    assign wait_st     = (state == ST_WRESP) || (state == ST_RDATA);
    assign idle_or_rsp = (state == ST_IDLE) || (state == ST_RSP);
    assign stray_inc   = idle_or_rsp ? (2'(M_AXI_BVALID) + 2'(M_AXI_RVALID)) : 2'd0;

    // Ready lines decode straight from the state register.
    assign REQ_READY    = ARESETN && (state == ST_IDLE);
    assign M_AXI_BREADY = (state == ST_WRESP) || idle_or_rsp;
    assign M_AXI_RREADY = (state == ST_RDATA) || idle_or_rsp;

    assign M_AXI_AWADDR = addr_q;
    assign M_AXI_ARADDR = addr_q;
    assign M_AXI_WDATA  = wdata_q;
    assign M_AXI_WSTRB  = wstrb_q;

    // Not being in a wait state clears the counter, so every wait starts at zero.
    mmio_timeout_ctr #(
        .TIMEOUT (TIMEOUT)
    ) u_timeout (
        .ACLK     (ACLK),
        .ARESETN  (ARESETN),
        .clear    (!wait_st),
        .enable   (wait_st),
        .expire_c (expire)
    );

    always_ff @(posedge ACLK) begin
        if (!ARESETN) begin
            state         <= ST_IDLE;
            M_AXI_AWVALID <= 1'b0;
            M_AXI_WVALID  <= 1'b0;
            M_AXI_ARVALID <= 1'b0;
            RSP_VALID     <= 1'b0;
            RSP_RDATA     <= '0;
            RSP_RESP      <= RESP_OKAY;
            RSP_TIMEOUT   <= 1'b0;
            STRAY_CNT     <= '0;
            aw_done       <= 1'b0;
            w_done        <= 1'b0;
            addr_q        <= '0;
            wdata_q       <= '0;
            wstrb_q       <= '0;
        end else begin
            STRAY_CNT <= stray_add(STRAY_CNT, stray_inc);
            case (state)
                ST_IDLE: begin
                    if (REQ_VALID) begin
                        addr_q  <= REQ_ADDR;
                        wdata_q <= REQ_WDATA;
                        wstrb_q <= REQ_WSTRB;
                        aw_done <= 1'b0;
                        w_done  <= 1'b0;
                        if (REQ_WRITE) begin
                            state         <= ST_WADDR;
                            M_AXI_AWVALID <= 1'b1;
                            M_AXI_WVALID  <= 1'b1;
                        end else begin
                            state         <= ST_RADDR;
                            M_AXI_ARVALID <= 1'b1;
                        end
                    end
                end
                // AW and W retire independently; leave once both have.
                ST_WADDR: begin
                    if (aw_hs) begin
                        M_AXI_AWVALID <= 1'b0;
                        aw_done       <= 1'b1;
                    end
                    if (w_hs) begin
                        M_AXI_WVALID <= 1'b0;
                        w_done       <= 1'b1;
                    end
                    if ((aw_done || aw_hs) && (w_done || w_hs)) begin
                        state <= ST_WRESP;
                    end
                end
                ST_WRESP: begin
                    if (M_AXI_BVALID) begin
                        RSP_RESP    <= M_AXI_BRESP;
                        RSP_RDATA   <= '0;
                        RSP_TIMEOUT <= 1'b0;
                        RSP_VALID   <= 1'b1;
                        state       <= ST_RSP;
                    end else if (expire) begin
                        RSP_RESP    <= RESP_SLVERR;
                        RSP_RDATA   <= '0;
                        RSP_TIMEOUT <= 1'b1;
                        RSP_VALID   <= 1'b1;
                        state       <= ST_RSP;
                    end
                end
                ST_RADDR: begin
                    if (ar_hs) begin
                        M_AXI_ARVALID <= 1'b0;
                        state         <= ST_RDATA;
                    end
                end
                ST_RDATA: begin
                    if (M_AXI_RVALID) begin
                        RSP_RESP    <= M_AXI_RRESP;
                        RSP_RDATA   <= M_AXI_RDATA;
                        RSP_TIMEOUT <= 1'b0;
                        RSP_VALID   <= 1'b1;
                        state       <= ST_RSP;
                    end else if (expire) begin
                        RSP_RESP    <= RESP_SLVERR;
                        RSP_RDATA   <= '0;
                        RSP_TIMEOUT <= 1'b1;
                        RSP_VALID   <= 1'b1;
                        state       <= ST_RSP;
                    end
                end
                ST_RSP: begin
                    if (RSP_READY) begin
                        RSP_VALID <= 1'b0;
                        state     <= ST_IDLE;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule
